// File: rtl/clause_bank_scan.sv
// clause_bank_scan: clause storage bank plus a sequential unit-propagation scanner.
// One clause slot is evaluated per cycle against var_value_i. Implications leave
// through a ready/valid handshake. The scan stops at the first conflict and reports
// an all-satisfied summary at the end.
//
// Optional feature macro: CLAUSE_BANK_PARTICIPATE_EN builds the participate_o
// register. When the macro is undefined, participate_o is tied to zero.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   var_value_i                   2 bits per variable: 01 true, 10 false, 00/11 unassigned
//   wr_valid_i/wr_ready_o         clause write handshake into slot wr_idx_i
//   clause_i, clause_len_i        clause literals (01 pos, 10 neg, 00/11 absent) and stored length
//   clear_i                       invalidate all slots (IDLE only)
//   rd_en_i, rd_idx_i             registered read request
//   rd_valid_o, clause_o, clause_len_o   read response, zeros for empty/out-of-range slots
//   eval_start_i, busy_o, done_o  scan control and status
//   imply_valid_o/imply_ready_i   implication handshake; imply_var_o, imply_val_o, imply_cid_o
//   conflict_o, conflict_cid_o    first conflict found in the last scan
//   all_c_sat_o                   every valid clause was satisfied in the last scan
//   participate_o                 OR of literal-present masks over valid slots
module clause_bank_scan #(
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned WIDTH_C_LEN = 4,
  localparam int unsigned CID_W      = $clog2(NUM_CLAUSES),
  localparam int unsigned VID_W      = $clog2(NUM_VARS),
  localparam int unsigned CL_W       = NUM_VARS * 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CL_W-1:0]        var_value_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [CID_W-1:0]       wr_idx_i,
  input  logic [CL_W-1:0]        clause_i,
  input  logic [WIDTH_C_LEN-1:0] clause_len_i,
  input  logic                   clear_i,
  input  logic                   rd_en_i,
  input  logic [CID_W-1:0]       rd_idx_i,
  output logic                   rd_valid_o,
  output logic [CL_W-1:0]        clause_o,
  output logic [WIDTH_C_LEN-1:0] clause_len_o,
  input  logic                   eval_start_i,
  output logic                   busy_o,
  output logic                   imply_valid_o,
  input  logic                   imply_ready_i,
  output logic [VID_W-1:0]       imply_var_o,
  output logic                   imply_val_o,
  output logic [CID_W-1:0]       imply_cid_o,
  output logic                   done_o,
  output logic                   conflict_o,
  output logic [CID_W-1:0]       conflict_cid_o,
  output logic                   all_c_sat_o,
  output logic [NUM_VARS-1:0]    participate_o
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_IMP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CID_W-1:0]       idx_q, idx_d;
  logic                   sat_acc_q, sat_acc_d;

  logic [CL_W-1:0]        clause_mem [NUM_CLAUSES];
  logic [WIDTH_C_LEN-1:0] len_mem    [NUM_CLAUSES];
  logic [NUM_CLAUSES-1:0] vld_q;

  logic                   wr_en, clear_en;
  logic [CL_W-1:0]        rd_clause_c;
  logic [WIDTH_C_LEN-1:0] rd_len_c;
  logic [CL_W-1:0]        cur_clause;
  logic                   cur_vld;
  logic [1:0]             lit, val;
  logic                   any_true, any_una, multi_una, unit_val;
  logic [VID_W-1:0]       unit_var;
  logic                   cur_sat, cur_conf, cur_unit, last_slot;

  logic                   busy_d, done_d, imply_valid_d, imply_val_d;
  logic [VID_W-1:0]       imply_var_d;
  logic [CID_W-1:0]       imply_cid_d, conflict_cid_d;
  logic                   conflict_d, all_c_sat_d;

  // Writes and clears are only taken while idle; clear wins over a write
  assign wr_ready_o = (state_q == IDLE) && !clear_i;
  assign wr_en      = wr_valid_i && wr_ready_o;
  assign clear_en   = clear_i && (state_q == IDLE);

  // Slot valid bits; an out-of-range index matches no slot and is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (clear_en) begin
      vld_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NUM_CLAUSES); i++)
        if (wr_idx_i == CID_W'(i)) vld_q[i] <= 1'b1;
    end
  end

  // Clause payload storage; contents are qualified by vld_q so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(NUM_CLAUSES); i++) begin
        if (wr_idx_i == CID_W'(i)) begin
          clause_mem[i] <= clause_i;
          len_mem[i]    <= clause_len_i;
        end
      end
    end
  end

  // Read mux: empty or out-of-range slots read as zero
  always_comb begin
    rd_clause_c = '0;
    rd_len_c    = '0;
    for (int i = 0; i < int'(NUM_CLAUSES); i++) begin
      if (rd_idx_i == CID_W'(i) && vld_q[i]) begin
        rd_clause_c = clause_mem[i];
        rd_len_c    = len_mem[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_o   <= 1'b0;
      clause_o     <= '0;
      clause_len_o <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        clause_o     <= rd_clause_c;
        clause_len_o <= rd_len_c;
      end
    end
  end

  // Slot under scan
  always_comb begin
    cur_clause = '0;
    cur_vld    = 1'b0;
    for (int i = 0; i < int'(NUM_CLAUSES); i++) begin
      if (idx_q == CID_W'(i)) begin
        cur_clause = clause_mem[i];
        cur_vld    = vld_q[i];
      end
    end
  end

  // Literal evaluation: a literal is true when the value code equals its polarity code
  always_comb begin
    lit       = '0;
    val       = '0;
    any_true  = 1'b0;
    any_una   = 1'b0;
    multi_una = 1'b0;
    unit_var  = '0;
    unit_val  = 1'b0;
    for (int v = 0; v < int'(NUM_VARS); v++) begin
      lit = cur_clause[2*v +: 2];
      val = var_value_i[2*v +: 2];
      if (lit == 2'b01 || lit == 2'b10) begin
        if (val == lit) begin
          any_true = 1'b1;
        end else if (val == 2'b00 || val == 2'b11) begin
          multi_una = multi_una | any_una;
          any_una   = 1'b1;
          unit_var  = VID_W'(v);
          unit_val  = lit[0];
        end
      end
    end
  end

  assign cur_sat   = any_true;
  assign cur_conf  = !any_true && !any_una;
  assign cur_unit  = !any_true && any_una && !multi_una;
  assign last_slot = (idx_q == CID_W'(NUM_CLAUSES - 1));

  // Scan FSM next-state and registered-output values
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sat_acc_d      = sat_acc_q;
    imply_var_d    = imply_var_o;
    imply_val_d    = imply_val_o;
    imply_cid_d    = imply_cid_o;
    conflict_d     = conflict_o;
    conflict_cid_d = conflict_cid_o;
    all_c_sat_d    = all_c_sat_o;
    case (state_q)
      IDLE: begin
        if (eval_start_i) begin
          state_d     = SCAN;
          idx_d       = '0;
          sat_acc_d   = 1'b1;
          conflict_d  = 1'b0;
          all_c_sat_d = 1'b0;
        end
      end
      SCAN: begin
        if (cur_vld && !cur_sat) sat_acc_d = 1'b0;
        if (cur_vld && cur_conf) begin
          conflict_d     = 1'b1;
          conflict_cid_d = idx_q;
          state_d        = DONE;
        end else if (cur_vld && cur_unit) begin
          imply_var_d = unit_var;
          imply_val_d = unit_val;
          imply_cid_d = idx_q;
          state_d     = WAIT_IMP;
        end else if (last_slot) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + CID_W'(1);
        end
      end
      WAIT_IMP: begin
        if (imply_ready_i) begin
          if (last_slot) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + CID_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Summary is latched on entry to DONE so it is visible alongside done_o
    if (state_d == DONE && state_q != DONE) all_c_sat_d = sat_acc_d && !conflict_d;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    imply_valid_d = (state_d == WAIT_IMP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      sat_acc_q      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      imply_valid_o  <= 1'b0;
      imply_var_o    <= '0;
      imply_val_o    <= 1'b0;
      imply_cid_o    <= '0;
      conflict_o     <= 1'b0;
      conflict_cid_o <= '0;
      all_c_sat_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      sat_acc_q      <= sat_acc_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      imply_valid_o  <= imply_valid_d;
      imply_var_o    <= imply_var_d;
      imply_val_o    <= imply_val_d;
      imply_cid_o    <= imply_cid_d;
      conflict_o     <= conflict_d;
      conflict_cid_o <= conflict_cid_d;
      all_c_sat_o    <= all_c_sat_d;
    end
  end

`ifdef CLAUSE_BANK_PARTICIPATE_EN
  logic [NUM_VARS-1:0] part_c;

  // A literal is present when its two code bits differ
  always_comb begin
    part_c = '0;
    for (int i = 0; i < int'(NUM_CLAUSES); i++)
      for (int v = 0; v < int'(NUM_VARS); v++)
        part_c[v] = part_c[v] | (vld_q[i] & (^clause_mem[i][2*v +: 2]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) participate_o <= '0;
    else      participate_o <= part_c;
  end
`else
  assign participate_o = '0;
`endif

endmodule
